// File: rtl/gig_ethernet_pcs_pma_bs_reset_seq_if.sv
// Control/status bundle between the bitslice reset sequencer (slave side) and its
// controlling fabric (master side).
interface gig_ethernet_pcs_pma_bs_reset_seq_if #(
    parameter int NUM_CH = 4
);
    logic              start_rst;
    logic [NUM_CH-1:0] ch_mask;
    logic              pll_locked;
    logic [NUM_CH-1:0] dly_rdy;
    logic [NUM_CH-1:0] vtc_rdy;
    logic              bsc_rst;
    logic              bs_rst;
    logic              rst_dly;
    logic              en_vtc;
    logic              logic_rst;
    logic              done;
    logic              timeout_err;
    logic [2:0]        state;
    logic [3:0]        retry_cnt;

    modport master (
        output start_rst, ch_mask, pll_locked, dly_rdy, vtc_rdy,
        input  bsc_rst, bs_rst, rst_dly, en_vtc, logic_rst, done,
        input  timeout_err, state, retry_cnt
    );

    modport slave (
        input  start_rst, ch_mask, pll_locked, dly_rdy, vtc_rdy,
        output bsc_rst, bs_rst, rst_dly, en_vtc, logic_rst, done,
        output timeout_err, state, retry_cnt
    );
endinterface

// File: rtl/gig_ethernet_pcs_pma_bs_reset_seq.sv
// Moore reset sequencer for the PCS/PMA bitslice nibbles: PLL lock, bitslice release,
// delay-ready and VTC-ready handshakes. Optional wait-state timeout: BS_RST_TIMEOUT_EN.
module gig_ethernet_pcs_pma_bs_reset_seq #(
    parameter int NUM_CH         = 4,
    parameter int RST_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset_n,
    gig_ethernet_pcs_pma_bs_reset_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_REL_BS    = 3'd2,
        S_REL_BSC   = 3'd3,
        S_EN_VTC    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int CW = $clog2(RST_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(RST_CYCLES - 1);

    // Output bundle order: {bsc_rst, bs_rst, rst_dly, logic_rst, en_vtc, done}
    function automatic logic [5:0] outs_of(input state_t s);
        logic [5:0] o;
        case (s)
            S_RST, S_WAIT_LOCK: o = 6'b111100;
            S_REL_BS:           o = 6'b100100;
            S_REL_BSC:          o = 6'b000100;
            S_EN_VTC:           o = 6'b000110;
            S_DONE:             o = 6'b000011;
            default:            o = 6'b111100;
        endcase
        return o;
    endfunction

    state_t            state_r;
    state_t            state_n_s;
    logic [CW-1:0]     dwell_r;
    logic [NUM_CH-1:0] mask_r;
    logic [5:0]        outs_r;
    logic              dly_ok_s;
    logic              vtc_ok_s;
    logic              pll_drop_s;
    logic              tmo_hit_s;
    logic              tmo_evt_s;

`ifdef BS_RST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_r;
    logic          timeout_err_r;
    logic [3:0]    retry_r;

    assign tmo_hit_s = (tmo_r == TMO_LAST);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Ready checks ignore channels excluded by the latched mask
    always_comb begin
        dly_ok_s   = &(bus.dly_rdy | ~mask_r);
        vtc_ok_s   = &(vtc_ready_masked(bus.vtc_rdy, mask_r));
        pll_drop_s = !bus.pll_locked && (state_r inside {S_REL_BS, S_REL_BSC, S_EN_VTC, S_DONE});
    end

    function automatic logic [NUM_CH-1:0] vtc_ready_masked(input logic [NUM_CH-1:0] rdy,
                                                           input logic [NUM_CH-1:0] msk);
        return rdy | ~msk;
    endfunction

    // Next-state decision; soft reset outranks lock loss, which outranks ready/timeout
    always_comb begin
        state_n_s = state_r;
        tmo_evt_s = 1'b0;
        if (bus.start_rst) begin
            state_n_s = S_RST;
        end else if (pll_drop_s) begin
            state_n_s = S_RST;
        end else begin
            case (state_r)
                S_RST: begin
                    if (dwell_r == DWELL_LAST) state_n_s = S_WAIT_LOCK;
                    else                       state_n_s = S_RST;
                end
                S_WAIT_LOCK: begin
                    if (bus.pll_locked) begin
                        state_n_s = S_REL_BS;
                    end else if (tmo_hit_s) begin
                        state_n_s = S_RST;
                        tmo_evt_s = 1'b1;
                    end else begin
                        state_n_s = S_WAIT_LOCK;
                    end
                end
                S_REL_BS: begin
                    if (dwell_r == DWELL_LAST) state_n_s = S_REL_BSC;
                    else                       state_n_s = S_REL_BS;
                end
                S_REL_BSC: begin
                    if (dly_ok_s) begin
                        state_n_s = S_EN_VTC;
                    end else if (tmo_hit_s) begin
                        state_n_s = S_RST;
                        tmo_evt_s = 1'b1;
                    end else begin
                        state_n_s = S_REL_BSC;
                    end
                end
                S_EN_VTC: begin
                    if (vtc_ok_s) begin
                        state_n_s = S_DONE;
                    end else if (tmo_hit_s) begin
                        state_n_s = S_RST;
                        tmo_evt_s = 1'b1;
                    end else begin
                        state_n_s = S_EN_VTC;
                    end
                end
                S_DONE:  state_n_s = S_DONE;
                default: state_n_s = S_RST;
            endcase
        end
    end

    // State, counters, mask latch and outputs all load together so outputs track state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_RST;
            dwell_r <= '0;
            mask_r  <= '1;
            outs_r  <= outs_of(S_RST);
`ifdef BS_RST_TIMEOUT_EN
            tmo_r         <= '0;
            timeout_err_r <= 1'b0;
            retry_r       <= 4'd0;
`endif
        end else begin
            state_r <= state_n_s;
            outs_r  <= outs_of(state_n_s);
            if (bus.start_rst || (state_n_s != state_r)) begin
                dwell_r <= '0;
            end else if (state_r inside {S_RST, S_REL_BS}) begin
                dwell_r <= dwell_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                dwell_r <= '0;
            end
            if ((state_r == S_RST) && (state_n_s == S_WAIT_LOCK)) begin
                mask_r <= bus.ch_mask;
            end else begin
                mask_r <= mask_r;
            end
`ifdef BS_RST_TIMEOUT_EN
            if (bus.start_rst || (state_n_s != state_r)) begin
                tmo_r <= '0;
            end else if (state_r inside {S_WAIT_LOCK, S_REL_BSC, S_EN_VTC}) begin
                tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                tmo_r <= '0;
            end
            timeout_err_r <= tmo_evt_s;
            if (tmo_evt_s && (retry_r != 4'd15)) begin
                retry_r <= retry_r + 4'd1;
            end else begin
                retry_r <= retry_r;
            end
`endif
        end
    end

    assign {bus.bsc_rst, bus.bs_rst, bus.rst_dly, bus.logic_rst, bus.en_vtc, bus.done} = outs_r;
    assign bus.state = state_r;

`ifdef BS_RST_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_r;
    assign bus.retry_cnt   = retry_r;
`else
    assign bus.timeout_err = 1'b0;
    assign bus.retry_cnt   = 4'd0;
`endif
endmodule
